// File: rtl/ad80305_spi_pkg.sv
// Shared definitions for the AD80305-style 3-wire+CS register bus.
// Used by the fabric target (register-file emulation) and by the master driver.
package ad80305_spi_pkg;

   localparam int CMD_BITS  = 16;
   localparam int DATA_BITS = 8;
   localparam int ADDR_W    = 10;
   localparam int MOD_W     = 3;

   // Command word field positions, MSB first on the wire
   localparam int CMD_RW_BIT  = 15;
   localparam int CMD_MOD_HI  = 14;
   localparam int CMD_MOD_LO  = 12;
   localparam int CMD_RSV_HI  = 11;
   localparam int CMD_RSV_LO  = 10;
   localparam int CMD_ADDR_HI = 9;
   localparam int CMD_ADDR_LO = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      WDATA = 3'd2,
      RDATA = 3'd3,
      DONE  = 3'd4
   } spi_state_e;

   // Field layout mirrors the positions above: {RW, MOD[2:0], RSV[1:0], ADDR[9:0]}
   typedef struct packed {
      logic              rw;
      logic [MOD_W-1:0]  mod;
      logic [1:0]        rsv;
      logic [ADDR_W-1:0] addr;
   } spi_cmd_t;

   function automatic spi_cmd_t cmd_decode(input logic [CMD_BITS-1:0] w);
      return spi_cmd_t'(w);
   endfunction

endpackage

// File: rtl/ad80305_regfile.sv
// Emulated register file: N_REGS x 8 bits, two write ports (SPI wins on a
// same-address collision) and two registered read ports. Addresses at or
// above N_REGS read as zero and silently drop writes.
module ad80305_regfile
   import ad80305_spi_pkg::*;
#(
   parameter int N_REGS = 64
) (
   input  logic                 i_fpga_clk_125p,
   input  logic                 i_fpga_rst_125p,
   input  logic                 spi_we,
   input  logic [ADDR_W-1:0]    spi_addr,
   input  logic [DATA_BITS-1:0] spi_wdata,
   input  logic                 loc_we,
   input  logic [ADDR_W-1:0]    loc_addr,
   input  logic [DATA_BITS-1:0] loc_wdata,
   input  logic [ADDR_W-1:0]    rd_a_addr,
   output logic [DATA_BITS-1:0] rd_a_data,
   input  logic [ADDR_W-1:0]    rd_b_addr,
   output logic [DATA_BITS-1:0] rd_b_data
);

   localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int LW = ADDR_W + 1;
   localparam logic [LW-1:0] LIMIT = LW'(N_REGS);

   logic [DATA_BITS-1:0] mem [N_REGS];

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < LIMIT;
   endfunction

   // Storage; the SPI write is applied last so it overrides a fabric write to the same entry
   always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
      if (!i_fpga_rst_125p) begin
         for (int i = 0; i < N_REGS; i++) mem[i] <= '0;
      end else begin
         if (loc_we && in_range(loc_addr)) mem[loc_addr[AW-1:0]] <= loc_wdata;
         if (spi_we && in_range(spi_addr)) mem[spi_addr[AW-1:0]] <= spi_wdata;
      end
   end

   // Registered reads, no write bypass
   always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
      if (!i_fpga_rst_125p) begin
         rd_a_data <= '0;
         rd_b_data <= '0;
      end else begin
         rd_a_data <= in_range(rd_a_addr) ? mem[rd_a_addr[AW-1:0]] : '0;
         rd_b_data <= in_range(rd_b_addr) ? mem[rd_b_addr[AW-1:0]] : '0;
      end
   end

endmodule

// File: rtl/ad80305_spi_target.sv
// AD80305-style SPI target. SPI pins are oversampled in the 125 MHz domain,
// a 16-bit command is decoded and followed by MOD+1 data bytes with address
// auto-increment. Backed by an emulated register file shared with the fabric.
module ad80305_spi_target
   import ad80305_spi_pkg::*;
#(
   parameter int N_REGS  = 64,
   parameter int SYNC_FF = 2
) (
   input  logic        i_fpga_clk_125p,
   input  logic        i_fpga_rst_125p,
   input  logic        i_spi_clk,
   input  logic        i_spi_cs_n,
   input  logic        i_spi_di,
   output logic        o_spi_do,
   output logic        o_spi_do_oe,
   input  logic        i_loc_we,
   input  logic [9:0]  i_loc_addr,
   input  logic [7:0]  i_loc_wdata,
   output logic [7:0]  o_loc_rdata,
   output logic        o_wr_stb,
   output logic [9:0]  o_wr_addr,
   output logic [7:0]  o_wr_data,
   output logic        o_frame_err
);

   logic [SYNC_FF-1:0] sclk_sync, cs_sync, di_sync;
   logic               sclk_d, cs_d;
   logic               sclk_q, cs_q, di_q;
   logic               sclk_rise, sclk_fall, cs_fall, cs_rise;

   spi_state_e              state_q, state_d;
   logic [3:0]              bit_cnt;
   logic [3:0]              byte_cnt;
   logic [MOD_W-1:0]        mod_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [CMD_BITS-2:0]     cmd_sr;
   logic [DATA_BITS-2:0]    wr_sr;
   logic [DATA_BITS-1:0]    rd_sr;
   logic                    last_q;
   logic [1:0]              rd_vld_pipe;
   logic [DATA_BITS-1:0]    rd_b_data;

   logic [CMD_BITS-1:0]     cmd_w;
   spi_cmd_t                cmd;
   logic                    cmd_done, wr_commit, rd_byte_end, rd_issue, frame_err_d;
   logic                    cmd_rsv_unused;

   assign sclk_q    = sclk_sync[SYNC_FF-1];
   assign cs_q      = cs_sync[SYNC_FF-1];
   assign di_q      = di_sync[SYNC_FF-1];
   assign sclk_rise = sclk_q & ~sclk_d;
   assign sclk_fall = ~sclk_q & sclk_d;
   assign cs_fall   = ~cs_q & cs_d;
   assign cs_rise   = cs_q & ~cs_d;

   assign cmd_w          = {cmd_sr, di_q};
   assign cmd            = cmd_decode(cmd_w);
   assign cmd_rsv_unused = ^cmd.rsv;
   assign rd_issue       = (cmd_done & ~cmd.rw) | rd_byte_end;

   // Pin synchronisers plus one edge-detect stage. cs_n chain resets low so a
   // master still mid-frame when reset releases does not produce a false cs_n fall.
   always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
      if (!i_fpga_rst_125p) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         di_sync   <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_FF-2:0], i_spi_clk};
         cs_sync   <= {cs_sync[SYNC_FF-2:0], i_spi_cs_n};
         di_sync   <= {di_sync[SYNC_FF-2:0], i_spi_di};
         sclk_d    <= sclk_q;
         cs_d      <= cs_q;
      end
   end

   // FSM state register
   always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
      if (!i_fpga_rst_125p) state_q <= IDLE;
      else                  state_q <= state_d;
   end

   // Next state and per-event control strobes
   always_comb begin
      state_d     = state_q;
      cmd_done    = 1'b0;
      wr_commit   = 1'b0;
      rd_byte_end = 1'b0;
      frame_err_d = 1'b0;
      if (cs_q) begin
         state_d = IDLE;
         if (cs_rise && (state_q == CMD ||
             ((state_q == WDATA || state_q == RDATA) && bit_cnt != 4'd0)))
            frame_err_d = 1'b1;
      end else begin
         case (state_q)
            IDLE:  if (cs_fall) state_d = CMD;
            CMD:   if (sclk_rise && bit_cnt == 4'(CMD_BITS-1)) begin
                      cmd_done = 1'b1;
                      state_d  = cmd.rw ? WDATA : RDATA;
                   end
            WDATA: if (sclk_rise && bit_cnt == 4'(DATA_BITS-1)) begin
                      wr_commit = 1'b1;
                      if (byte_cnt == {1'b0, mod_q}) state_d = DONE;
                   end
            RDATA: begin
                      if (sclk_fall && !last_q && bit_cnt == 4'(DATA_BITS-1)) rd_byte_end = 1'b1;
                      // hold the final bit until the master has sampled it
                      if (sclk_rise && last_q) state_d = DONE;
                   end
            default: ;
         endcase
      end
   end

   // Read-data pipeline: address settles, then registered regfile output is valid
   always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
      if (!i_fpga_rst_125p) rd_vld_pipe <= '0;
      else                  rd_vld_pipe <= {rd_vld_pipe[0], rd_issue};
   end

   // Shift registers, counters, address and pin/strobe outputs
   always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
      if (!i_fpga_rst_125p) begin
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         mod_q       <= '0;
         addr_q      <= '0;
         cmd_sr      <= '0;
         wr_sr       <= '0;
         rd_sr       <= '0;
         last_q      <= 1'b0;
         o_spi_do    <= 1'b0;
         o_spi_do_oe <= 1'b0;
         o_wr_stb    <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_wr_stb    <= 1'b0;
         o_frame_err <= frame_err_d;
         if (cs_q) begin
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            last_q      <= 1'b0;
            o_spi_do    <= 1'b0;
            o_spi_do_oe <= 1'b0;
         end else begin
            case (state_q)
               CMD: if (sclk_rise) begin
                  cmd_sr  <= cmd_w[CMD_BITS-2:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (cmd_done) begin
                     bit_cnt <= '0;
                     mod_q   <= cmd.mod;
                     addr_q  <= cmd.addr;
                  end
               end
               WDATA: if (sclk_rise) begin
                  wr_sr   <= {wr_sr[DATA_BITS-3:0], di_q};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (wr_commit) begin
                     bit_cnt   <= '0;
                     o_wr_stb  <= 1'b1;
                     o_wr_addr <= addr_q;
                     o_wr_data <= {wr_sr, di_q};
                     addr_q    <= addr_q + 10'd1;
                     byte_cnt  <= byte_cnt + 4'd1;
                  end
               end
               RDATA: begin
                  if (sclk_fall && !last_q) begin
                     o_spi_do    <= rd_sr[DATA_BITS-1];
                     o_spi_do_oe <= 1'b1;
                     rd_sr       <= {rd_sr[DATA_BITS-2:0], 1'b0};
                     bit_cnt     <= bit_cnt + 4'd1;
                     if (rd_byte_end) begin
                        bit_cnt  <= '0;
                        addr_q   <= addr_q + 10'd1;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == {1'b0, mod_q}) last_q <= 1'b1;
                     end
                  end
                  if (rd_vld_pipe[1]) rd_sr <= rd_b_data;
               end
               DONE: begin
                  o_spi_do    <= 1'b0;
                  o_spi_do_oe <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   ad80305_regfile #(.N_REGS(N_REGS)) u_regfile (
      .i_fpga_clk_125p (i_fpga_clk_125p),
      .i_fpga_rst_125p (i_fpga_rst_125p),
      .spi_we          (o_wr_stb),
      .spi_addr        (o_wr_addr),
      .spi_wdata       (o_wr_data),
      .loc_we          (i_loc_we),
      .loc_addr        (i_loc_addr),
      .loc_wdata       (i_loc_wdata),
      .rd_a_addr       (i_loc_addr),
      .rd_a_data       (o_loc_rdata),
      .rd_b_addr       (addr_q),
      .rd_b_data       (rd_b_data)
   );

endmodule

// File: tb/tb_ad80305_spi_target.sv
// Directed bench for ad80305_spi_target: bit-banged SPI master, fabric port
// driver and a strobe/frame-error monitor.
module tb_ad80305_spi_target;
   import ad80305_spi_pkg::*;

   localparam int HALF = 32;   // sclk half period in clk cycles (~1.95 MHz)

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       sclk = 1'b0, cs_n = 1'b1, di = 1'b0;
   logic       spi_do, spi_do_oe;
   logic       loc_we = 1'b0;
   logic [9:0] loc_addr = '0;
   logic [7:0] loc_wdata = '0;
   logic [7:0] loc_rdata;
   logic       wr_stb, frame_err;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;

   int errors = 0, checks = 0;
   logic [9:0] stb_addr_q [$];
   logic [7:0] stb_data_q [$];
   int         ferr_cnt = 0;
   logic [7:0] wbuf [8];
   logic [7:0] rbuf [8];
   int         oe_cnt;

   always #4 clk = ~clk;

   ad80305_spi_target #(.N_REGS(64), .SYNC_FF(2)) dut (
      .i_fpga_clk_125p (clk),
      .i_fpga_rst_125p (rst_n),
      .i_spi_clk       (sclk),
      .i_spi_cs_n      (cs_n),
      .i_spi_di        (di),
      .o_spi_do        (spi_do),
      .o_spi_do_oe     (spi_do_oe),
      .i_loc_we        (loc_we),
      .i_loc_addr      (loc_addr),
      .i_loc_wdata     (loc_wdata),
      .o_loc_rdata     (loc_rdata),
      .o_wr_stb        (wr_stb),
      .o_wr_addr       (wr_addr),
      .o_wr_data       (wr_data),
      .o_frame_err     (frame_err)
   );

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_addr_q.push_back(wr_addr);
         stb_data_q.push_back(wr_data);
      end
      if (frame_err) ferr_cnt++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, output logic d, output logic oe);
      di = b;
      wait_clks(HALF);
      d  = spi_do;
      oe = spi_do_oe;
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
   endtask

   // full frame; nbits_max >= 0 truncates the frame (cs_n rises early)
   task automatic spi_frame(input logic [15:0] cmd, input int nbytes, input int nbits_max);
      logic d, oe, b;
      logic [7:0] sb;
      int total, k;
      total = 16 + 8 * nbytes;
      if (nbits_max >= 0 && nbits_max < total) total = nbits_max;
      oe_cnt = 0;
      for (int j = 0; j < 8; j++) rbuf[j] = '0;
      cs_n = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < total; i++) begin
         if (i < 16) b = cmd[15-i];
         else begin
            k  = i - 16;
            sb = wbuf[k/8];
            b  = sb[7 - (k % 8)];
         end
         spi_bit(b, d, oe);
         if (i >= 16) begin
            k = i - 16;
            rbuf[k/8][7 - (k % 8)] = d;
            if (oe) oe_cnt++;
         end
      end
      wait_clks(HALF);
      cs_n = 1'b1;
      wait_clks(HALF);
   endtask

   task automatic loc_read(input logic [9:0] a, output logic [7:0] d);
      loc_addr = a;
      wait_clks(1);
      d = loc_rdata;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      rst_n = 1'b0;
      wait_clks(5);
      checks++;
      if ({spi_do, spi_do_oe, wr_stb, frame_err, loc_rdata} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got do=%b oe=%b stb=%b ferr=%b rdata=%h, want all 0",
                  spi_do, spi_do_oe, wr_stb, frame_err, loc_rdata);
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
      end
      rst_n = 1'b1;
      wait_clks(10);
      loc_read(10'h000, d);
      checks++;
      if (d !== 8'h00 || spi_do_oe !== 1'b0) begin
         errors++; $display("FAIL reset_regfile: rdata=%h oe=%b, want 00/0", d, spi_do_oe);
      end
   endtask

   task automatic test_write;
      int n0, f0;
      logic [7:0] d;
      n0 = stb_addr_q.size(); f0 = ferr_cnt;
      wbuf[0] = 8'hA5;
      spi_frame(16'h8005, 1, -1);
      checks++;
      if (stb_addr_q.size() - n0 !== 1) begin
         errors++; $display("FAIL write_stb_count: got %0d want 1", stb_addr_q.size() - n0);
      end else begin
         checks++;
         if (stb_addr_q[n0] !== 10'h005 || stb_data_q[n0] !== 8'hA5) begin
            errors++; $display("FAIL write_stb_fields: got %h/%h want 005/a5", stb_addr_q[n0], stb_data_q[n0]);
         end
      end
      loc_read(10'h005, d);
      checks++;
      if (d !== 8'hA5) begin errors++; $display("FAIL write_loc_read: got %h want a5", d); end
      checks++;
      if (ferr_cnt != f0) begin errors++; $display("FAIL write_no_ferr: got %0d errs want 0", ferr_cnt - f0); end
   endtask

   task automatic test_read;
      for (int j = 0; j < 8; j++) wbuf[j] = '0;
      spi_frame(16'h0005, 1, -1);
      checks++;
      if (rbuf[0] !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", rbuf[0]); end
      checks++;
      if (oe_cnt != 8) begin errors++; $display("FAIL read_oe_bits: got %0d want 8", oe_cnt); end
      checks++;
      if (spi_do_oe !== 1'b0 || spi_do !== 1'b0) begin
         errors++; $display("FAIL read_idle_pins: got do=%b oe=%b want 0/0", spi_do, spi_do_oe);
      end
   endtask

   task automatic test_burst;
      int n0, f0;
      logic [7:0] d;
      logic [9:0] ea [4];
      logic [7:0] ed [4];
      ea = '{10'h3FF, 10'h000, 10'h001, 10'h002};
      ed = '{8'h11, 8'h22, 8'h33, 8'h44};
      n0 = stb_addr_q.size(); f0 = ferr_cnt;
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
      spi_frame(16'hB3FF, 4, -1);
      checks++;
      if (stb_addr_q.size() - n0 !== 4) begin
         errors++; $display("FAIL burst_stb_count: got %0d want 4", stb_addr_q.size() - n0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (stb_addr_q[n0+i] !== ea[i] || stb_data_q[n0+i] !== ed[i]) begin
               errors++; $display("FAIL burst_stb_%0d: got %h/%h want %h/%h", i,
                                  stb_addr_q[n0+i], stb_data_q[n0+i], ea[i], ed[i]);
            end
         end
      end
      loc_read(10'h002, d);
      checks++;
      if (d !== 8'h44) begin errors++; $display("FAIL burst_loc_002: got %h want 44", d); end
      loc_read(10'h3FF, d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL burst_loc_3ff_dropped: got %h want 00", d); end
      for (int j = 0; j < 8; j++) wbuf[j] = '0;
      spi_frame(16'h03FF, 1, -1);
      checks++;
      if (rbuf[0] !== 8'h00) begin errors++; $display("FAIL burst_spi_read_3ff: got %h want 00", rbuf[0]); end
      checks++;
      if (ferr_cnt != f0) begin errors++; $display("FAIL burst_no_ferr: got %0d want 0", ferr_cnt - f0); end
   endtask

   task automatic test_frame_err;
      int n0, f0;
      n0 = stb_addr_q.size(); f0 = ferr_cnt;
      spi_frame(16'h8007, 1, 11);
      checks++;
      if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt - f0); end
      checks++;
      if (stb_addr_q.size() != n0) begin errors++; $display("FAIL ferr_no_stb: got %0d want 0", stb_addr_q.size() - n0); end
      spi_frame(16'h0001, 1, -1);
      checks++;
      if (rbuf[0] !== 8'h33) begin errors++; $display("FAIL ferr_next_frame: got %h want 33", rbuf[0]); end
   endtask

   task automatic test_collision;
      int n;
      logic hit;
      logic [7:0] d;
      n = 0; hit = 1'b0;
      wbuf[0] = 8'h5A;
      fork
         spi_frame(16'h8010, 1, -1);
         begin
            loc_we = 1'b1; loc_addr = 10'h010; loc_wdata = 8'h77;
            while (!hit && n < 20000) begin
               @(posedge clk); #1; n++;
               if (wr_stb) begin hit = 1'b1; @(posedge clk); #1; end
            end
            loc_we = 1'b0;
         end
      join
      checks++;
      if (!hit) begin errors++; $display("FAIL collision_stb_timeout: got no stb want 1"); end
      loc_read(10'h010, d);
      checks++;
      if (d !== 8'h5A) begin errors++; $display("FAIL collision_priority: got %h want 5a", d); end
   endtask

   task automatic test_done_ignore;
      int n0, f0;
      n0 = stb_addr_q.size(); f0 = ferr_cnt;
      wbuf[0] = 8'h12; wbuf[1] = 8'h34;
      spi_frame(16'h8020, 2, -1);
      checks++;
      if (stb_addr_q.size() - n0 != 1) begin
         errors++; $display("FAIL done_stb_count: got %0d want 1", stb_addr_q.size() - n0);
      end else begin
         checks++;
         if (stb_addr_q[n0] !== 10'h020 || stb_data_q[n0] !== 8'h12) begin
            errors++; $display("FAIL done_stb_fields: got %h/%h want 020/12", stb_addr_q[n0], stb_data_q[n0]);
         end
      end
      checks++;
      if (ferr_cnt != f0) begin errors++; $display("FAIL done_no_ferr: got %0d want 0", ferr_cnt - f0); end
   endtask

   task automatic test_async_reset;
      logic d, oe;
      logic [15:0] cmd;
      logic [7:0] rd;
      int n0, oe_hi;
      cmd = 16'h0005;
      n0 = stb_addr_q.size();
      cs_n = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < 16; i++) spi_bit(cmd[15-i], d, oe);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, d, oe);
      wait_clks(6);
      checks++;
      if (spi_do_oe !== 1'b1) begin errors++; $display("FAIL areset_pre_oe: got %b want 1", spi_do_oe); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (spi_do !== 1'b0 || spi_do_oe !== 1'b0) begin
         errors++; $display("FAIL areset_pins: got do=%b oe=%b want 0/0", spi_do, spi_do_oe);
      end
      checks++;
      if (dut.state_q !== IDLE) begin errors++; $display("FAIL areset_state: got %0d want IDLE", dut.state_q); end
      wait_clks(3);
      rst_n = 1'b1;
      oe_hi = 0;
      for (int i = 0; i < 5; i++) begin
         spi_bit(1'b1, d, oe);
         if (oe) oe_hi++;
      end
      wait_clks(HALF);
      cs_n = 1'b1;
      wait_clks(HALF);
      checks++;
      if (oe_hi != 0 || stb_addr_q.size() != n0) begin
         errors++; $display("FAIL areset_remainder_ignored: got oe_hi=%0d stb=%0d want 0/0",
                            oe_hi, stb_addr_q.size() - n0);
      end
      for (int j = 0; j < 8; j++) wbuf[j] = '0;
      spi_frame(16'h0005, 1, -1);
      checks++;
      if (rbuf[0] !== 8'h00) begin errors++; $display("FAIL areset_read_cleared: got %h want 00", rbuf[0]); end
      loc_read(10'h010, rd);
      checks++;
      if (rd !== 8'h00) begin errors++; $display("FAIL areset_loc_cleared: got %h want 00", rd); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_burst();
      test_frame_err();
      test_collision();
      test_done_ignore();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
